chess_move_ctrl: RTL and testbench

CHESS_MOVE_CTRL -- requirements
Module: chess_move_ctrl

---
 rtl/chess_move_ctrl.sv | 168 ++++++++++++++++
 tb/tb_chess_move_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/chess_move_ctrl.sv
// Cursor-driven chess move controller: button edges move a cursor, select a source
// piece of the side to move, and commit a move as two board-memory writes.
module chess_move_ctrl #(
  parameter logic [5:0] CURSOR_INIT = 6'd50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_sel,
  input  logic       btn_cancel,
  output logic [5:0] rd_addr,
  input  logic [3:0] rd_data,
  output logic [5:0] cursor,
  output logic [5:0] src_tile,
  output logic       src_valid,
  output logic       wr_en,
  output logic [5:0] wr_addr,
  output logic [3:0] wr_data,
  output logic       turn,
  output logic       busy,
  output logic [7:0] move_count
);

  typedef enum logic [1:0] {S_IDLE, S_SRC, S_WR0, S_WR1} state_t;

  state_t      r_state, w_state_nxt;
  logic [5:0]  r_cursor, w_cursor_nxt;
  logic [5:0]  r_src_tile, w_src_tile_nxt;
  logic        r_src_valid, w_src_valid_nxt;
  logic [5:0]  r_dst, w_dst_nxt;
  logic [3:0]  r_src_piece, w_src_piece_nxt;
  logic        r_turn, w_turn_nxt;
  logic [7:0]  r_move_count, w_move_count_nxt;
  logic [5:0]  r_prev, w_prev_nxt;

  logic [5:0]  w_btn;
  logic [5:0]  w_edge;
  logic        w_own;
  logic        w_move;

  // Bit order: {cancel, sel, up, down, left, right}, highest priority first.
  assign w_btn  = {btn_cancel, btn_sel, btn_up, btn_down, btn_left, btn_right};
  assign w_edge = tick ? (w_btn & ~r_prev) : '0;
  assign w_own  = (rd_data != 4'd0) && (rd_data[3] == r_turn);

  always_comb begin
    w_state_nxt      = r_state;
    w_cursor_nxt     = r_cursor;
    w_src_tile_nxt   = r_src_tile;
    w_src_valid_nxt  = r_src_valid;
    w_dst_nxt        = r_dst;
    w_src_piece_nxt  = r_src_piece;
    w_turn_nxt       = r_turn;
    w_move_count_nxt = r_move_count;
    w_prev_nxt       = tick ? w_btn : r_prev;
    w_move           = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_edge[5]) begin
          w_state_nxt = S_IDLE;
        end else if (w_edge[4]) begin
          if (w_own) begin
            w_src_tile_nxt  = r_cursor;
            w_src_piece_nxt = rd_data;
            w_src_valid_nxt = 1'b1;
            w_state_nxt     = S_SRC;
          end
        end else begin
          w_move = 1'b1;
        end
      end
      S_SRC: begin
        if (w_edge[5]) begin
          w_src_valid_nxt = 1'b0;
          w_state_nxt     = S_IDLE;
        end else if (w_edge[4]) begin
          if (r_cursor == r_src_tile) begin
            w_src_valid_nxt = 1'b0;
            w_state_nxt     = S_IDLE;
          end else if (w_own) begin
            w_src_tile_nxt  = r_cursor;
            w_src_piece_nxt = rd_data;
          end else begin
            w_dst_nxt   = r_cursor;
            w_state_nxt = S_WR0;
          end
        end else begin
          w_move = 1'b1;
        end
      end
      S_WR0: w_state_nxt = S_WR1;
      S_WR1: begin
        w_state_nxt      = S_IDLE;
        w_turn_nxt       = ~r_turn;
        w_src_valid_nxt  = 1'b0;
        w_move_count_nxt = r_move_count + 8'd1;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // A saturated higher-priority direction still consumes the tick.
    if (w_move) begin
      if (w_edge[3]) begin
        if (r_cursor[5:3] != 3'd0) w_cursor_nxt = r_cursor - 6'd8;
      end else if (w_edge[2]) begin
        if (r_cursor[5:3] != 3'd7) w_cursor_nxt = r_cursor + 6'd8;
      end else if (w_edge[1]) begin
        if (r_cursor[2:0] != 3'd0) w_cursor_nxt = r_cursor - 6'd1;
      end else if (w_edge[0]) begin
        if (r_cursor[2:0] != 3'd7) w_cursor_nxt = r_cursor + 6'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_cursor     <= CURSOR_INIT;
      r_src_tile   <= '0;
      r_src_valid  <= 1'b0;
      r_dst        <= '0;
      r_src_piece  <= '0;
      r_turn       <= 1'b0;
      r_move_count <= '0;
      r_prev       <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cursor     <= w_cursor_nxt;
      r_src_tile   <= w_src_tile_nxt;
      r_src_valid  <= w_src_valid_nxt;
      r_dst        <= w_dst_nxt;
      r_src_piece  <= w_src_piece_nxt;
      r_turn       <= w_turn_nxt;
      r_move_count <= w_move_count_nxt;
      r_prev       <= w_prev_nxt;
    end
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    busy    = 1'b0;
    if (r_state == S_WR0) begin
      wr_en   = 1'b1;
      wr_addr = r_src_tile;
      busy    = 1'b1;
    end else if (r_state == S_WR1) begin
      wr_en   = 1'b1;
      wr_addr = r_dst;
      wr_data = r_src_piece;
      busy    = 1'b1;
    end
  end

  assign rd_addr    = r_cursor;
  assign cursor     = r_cursor;
  assign src_tile   = r_src_tile;
  assign src_valid  = r_src_valid;
  assign turn       = r_turn;
  assign move_count = r_move_count;

endmodule

// File: tb/tb_chess_move_ctrl.sv
// Directed bench for chess_move_ctrl with a small board memory answering reads
// combinationally and accepting the controller's writes.
module tb_chess_move_ctrl;

  localparam logic [5:0] B_CAN = 6'b100000;
  localparam logic [5:0] B_SEL = 6'b010000;
  localparam logic [5:0] B_UP  = 6'b001000;
  localparam logic [5:0] B_DN  = 6'b000100;
  localparam logic [5:0] B_LT  = 6'b000010;
  localparam logic [5:0] B_RT  = 6'b000001;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic [5:0] btns = '0;
  logic [5:0] rd_addr, cursor, src_tile, wr_addr;
  logic [3:0] rd_data, wr_data;
  logic       src_valid, wr_en, turn, busy;
  logic [7:0] move_count;

  logic [3:0] board [64] = '{default: 4'd0};
  logic       tb_we = 1'b0;
  logic [5:0] tb_waddr = '0;
  logic [3:0] tb_wdata = '0;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  always #5 clk = ~clk;

  chess_move_ctrl #(.CURSOR_INIT(6'd50)) dut (
    .clk(clk), .reset(reset), .tick(tick),
    .btn_up(btns[3]), .btn_down(btns[2]), .btn_left(btns[1]), .btn_right(btns[0]),
    .btn_sel(btns[4]), .btn_cancel(btns[5]),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .cursor(cursor), .src_tile(src_tile), .src_valid(src_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .turn(turn), .busy(busy), .move_count(move_count)
  );

  assign rd_data = board[rd_addr];

  always @(posedge clk) begin
    if (wr_en) board[wr_addr] <= wr_data;
    else if (tb_we) board[tb_waddr] <= tb_wdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick_btn(input logic [5:0] b);
    btns = b;
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
  endtask

  task automatic press(input logic [5:0] b);
    tick_btn(b);
    tick_btn(6'b0);
  endtask

  task automatic set_tile(input logic [5:0] a, input logic [3:0] d);
    tb_we = 1'b1; tb_waddr = a; tb_wdata = d;
    @(posedge clk); #1;
    tb_we = 1'b0;
  endtask

  logic [5:0] exp_c;
  logic       exp_t;
  logic [7:0] exp_mc;

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_cursor", cursor, 50);
    check("rst_rd_addr", rd_addr, 50);
    check("rst_valid", src_valid, 0);
    check("rst_turn", turn, 0);
    check("rst_mc", move_count, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_busy", busy, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // cursor walk up with saturation at row 0
    exp_c = 6'd50;
    for (int i = 0; i < 8; i++) begin
      press(B_UP);
      if (exp_c >= 6'd8) exp_c = exp_c - 6'd8;
      check("up_walk", cursor, exp_c);
    end
    press(B_RT);
    check("right_3", cursor, 3);

    // full move 52 -> 36
    set_tile(6'd52, 4'b0001);
    for (int i = 0; i < 6; i++) press(B_DN);
    press(B_RT);
    check("cursor_52", cursor, 52);
    press(B_SEL);
    check("sel_valid", src_valid, 1);
    check("sel_tile", src_tile, 52);
    press(B_UP);
    press(B_UP);
    check("cursor_36", cursor, 36);
    tick_btn(B_SEL);
    check("wr0_en", wr_en, 1);
    check("wr0_addr", wr_addr, 52);
    check("wr0_data", wr_data, 0);
    check("wr0_busy", busy, 1);
    tick_btn(6'b0);
    check("wr1_en", wr_en, 1);
    check("wr1_addr", wr_addr, 36);
    check("wr1_data", wr_data, 1);
    @(posedge clk); #1;
    check("mv_wr_en", wr_en, 0);
    check("mv_busy", busy, 0);
    check("mv_turn", turn, 1);
    check("mv_mc", move_count, 1);
    check("mv_valid", src_valid, 0);
    check("mv_board36", board[36], 1);
    check("mv_board52", board[52], 0);

    // black to move: white piece on 36 is not selectable
    press(B_SEL);
    check("own_w_valid", src_valid, 0);
    check("own_w_busy", busy, 0);

    // priority: sel wins over up/left in the same tick
    press(B_LT);
    set_tile(6'd35, 4'b1001);
    tick_btn(B_UP | B_LT | B_SEL);
    check("prio_valid", src_valid, 1);
    check("prio_tile", src_tile, 35);
    check("prio_cursor", cursor, 35);
    tick_btn(6'b0);
    for (int i = 0; i < 5; i++) tick_btn(B_UP);
    check("held_up", cursor, 27);
    tick_btn(6'b0);

    // cancel, deselect, reselect
    press(B_CAN);
    check("cancel_valid", src_valid, 0);
    check("cancel_tile", src_tile, 35);
    press(B_DN);
    press(B_SEL);
    check("resel_valid", src_valid, 1);
    press(B_SEL);
    check("desel_valid", src_valid, 0);
    check("desel_busy", busy, 0);
    press(B_SEL);
    set_tile(6'd34, 4'b1010);
    press(B_LT);
    press(B_SEL);
    check("switch_tile", src_tile, 34);
    check("switch_valid", src_valid, 1);
    check("switch_busy", busy, 0);

    // reset during WR1, with up held through reset
    press(B_LT);
    tick_btn(B_SEL);
    check("abort_wr0_addr", wr_addr, 34);
    tick_btn(6'b0);
    check("abort_wr1_data", wr_data, 4'b1010);
    btns = B_UP;
    reset = 1'b0;
    #1;
    check("abort_wr_en", wr_en, 0);
    check("abort_wr_addr", wr_addr, 0);
    check("abort_wr_data", wr_data, 0);
    check("abort_busy", busy, 0);
    check("abort_cursor", cursor, 50);
    check("abort_turn", turn, 0);
    check("abort_mc", move_count, 0);
    check("abort_valid", src_valid, 0);
    check("abort_tile", src_tile, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("held_rst_noedge", cursor, 50);
    tick_btn(B_UP);
    check("held_rst_edge", cursor, 42);
    tick_btn(B_UP);
    check("held_rst_once", cursor, 42);
    tick_btn(6'b0);

    // white to move: black piece rejected
    set_tile(6'd42, 4'b1001);
    press(B_SEL);
    check("own_b_valid", src_valid, 0);
    check("own_b_wr_en", wr_en, 0);

    // 256 moves: move_count wraps
    exp_t = 1'b0;
    exp_mc = 8'd0;
    for (int i = 0; i < 256; i++) begin
      set_tile(6'd42, {exp_t, 3'b001});
      press(B_SEL);
      press(B_RT);
      press(B_SEL);
      @(posedge clk); #1;
      press(B_LT);
      exp_t = ~exp_t;
      exp_mc = exp_mc + 8'd1;
      if (i == 254 || i == 255) begin
        check("wrap_mc", move_count, exp_mc);
        check("wrap_turn", turn, exp_t);
      end
    end
    check("wrap_cursor", cursor, 42);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
